// File: rtl/mtx_arb.sv
// mtx_arb: packet-level round-robin arbiter feeding one MIO transmit serializer
//   io_clk, nreset        : clock, async active-low reset
//   en                    : arbitration enable (blocks new grants only)
//   req_valid/last/vbytes/packet : per-requester beat inputs (sliced by index)
//   req_ready             : combinational beat accept per requester
//   io_valid, io_packet   : registered beat to the serializer
//   io_wait               : serializer pushback
//   grant, busy           : registered one-hot owner and packet-in-flight flag
module mtx_arb #(
  parameter int N  = 4,
  parameter int PW = 64
) (
  input  logic            io_clk,
  input  logic            nreset,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*8-1:0]  req_vbytes,
  input  logic [N*PW-1:0] req_packet,
  output logic [N-1:0]    req_ready,
  output logic [7:0]      io_valid,
  output logic [PW-1:0]   io_packet,
  input  logic            io_wait,
  output logic [N-1:0]    grant,
  output logic            busy
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [AW-1:0] ptr, owner, win;
  logic slot_free, accept;
  // lowest offset from ptr wins, so scan offsets high to low and let the last hit stand
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % N]) win = AW'((int'(ptr) + k) % N);
  end
  // an empty slot, or one the serializer drains this edge, can take a new beat
  assign slot_free = (io_valid == 8'd0) || !io_wait;
  assign req_ready = grant & req_valid & {N{busy & slot_free}};
  assign accept    = |req_ready;
  always_ff @(posedge io_clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      ptr       <= '0;
      owner     <= '0;
      io_valid  <= '0;
      io_packet <= '0;
    end else begin
      if (state == IDLE) begin
        if (en && |req_valid) begin
          state <= SEND;
          busy  <= 1'b1;
          grant <= {{(N-1){1'b0}}, 1'b1} << win;
          owner <= win;
        end
      end else if (accept && req_last[owner]) begin
        state <= IDLE;
        busy  <= 1'b0;
        grant <= '0;
        ptr   <= (owner == AW'(N - 1)) ? '0 : owner + 1'b1;
      end
      // a zero vbytes beat lands as io_valid=0, i.e. it is consumed and dropped
      if (accept) begin
        io_valid  <= req_vbytes[8*owner +: 8];
        io_packet <= req_packet[PW*owner +: PW];
      end else if (slot_free) begin
        io_valid  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mtx_arb.sv
// tb_mtx_arb: directed self-checking bench for mtx_arb
module tb_mtx_arb;
  logic io_clk = 0, nreset, en, io_wait, busy;
  logic [3:0] req_valid, req_last, req_ready, grant;
  logic [31:0] req_vbytes;
  logic [255:0] req_packet;
  logic [7:0] io_valid;
  logic [63:0] io_packet;
  int total = 0, bad = 0;
  int order [6] = '{0, 1, 3, 0, 1, 3};
  mtx_arb #(.N(4), .PW(64)) dut (
    .io_clk(io_clk), .nreset(nreset), .en(en), .req_valid(req_valid),
    .req_last(req_last), .req_vbytes(req_vbytes), .req_packet(req_packet),
    .req_ready(req_ready), .io_valid(io_valid), .io_packet(io_packet),
    .io_wait(io_wait), .grant(grant), .busy(busy)
  );
  always #5 io_clk = ~io_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge io_clk);
    #2;
  endtask
  task automatic drv(input int i, input logic v, input logic l, input logic [7:0] vb, input logic [63:0] d);
    req_valid[i] = v;
    req_last[i] = l;
    req_vbytes[8*i +: 8] = vb;
    req_packet[64*i +: 64] = d;
  endtask
  initial begin
    nreset = 0; en = 1; io_wait = 0;
    req_valid = '1; req_last = '0; req_vbytes = '1; req_packet = '1;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_io_valid", io_valid, 0);
    chk("rst_io_packet", io_packet, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_ptr", dut.ptr, 0);
    req_valid = '0;
    nreset = 1;
    // single 3-beat packet from req 0
    drv(0, 1, 0, 8'hFF, 64'hA1);
    #1 chk("t1_ready_idle", req_ready, 0);
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_io_valid0", io_valid, 0);
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_io_valid", io_valid, 8'hFF);
    chk("t1_pkt_a1", io_packet, 64'hA1);
    drv(0, 1, 0, 8'hFF, 64'hA2);
    tick();
    chk("t1_pkt_a2", io_packet, 64'hA2);
    drv(0, 1, 1, 8'hFF, 64'hA3);
    tick();
    chk("t1_pkt_a3", io_packet, 64'hA3);
    chk("t1_busy_end", busy, 0);
    chk("t1_grant_end", grant, 0);
    chk("t1_ptr", dut.ptr, 1);
    drv(0, 0, 0, 8'h00, 64'h0);
    tick();
    chk("t1_io_drain", io_valid, 0);
    // round robin among 0, 1, 3 from a fresh ptr=0
    nreset = 0;
    drv(0, 1, 1, 8'hFF, 64'h10);
    drv(1, 1, 1, 8'hFF, 64'h11);
    drv(3, 1, 1, 8'hFF, 64'h13);
    tick();
    nreset = 1;
    foreach (order[j]) begin
      tick();
      chk("rr_grant", grant, 64'd1 << order[j]);
      tick();
      chk("rr_gap", grant, 0);
      chk("rr_pkt", io_packet, 64'h10 + order[j]);
    end
    drv(0, 0, 0, 8'h00, 64'h0);
    drv(1, 0, 0, 8'h00, 64'h0);
    drv(3, 0, 0, 8'h00, 64'h0);
    // backpressure on req 2
    drv(2, 1, 0, 8'hFF, 64'hB1);
    tick();
    chk("bp_grant", grant, 4'b0100);
    #1 chk("bp_ready", req_ready, 4'b0100);
    tick();
    chk("bp_pkt_b1", io_packet, 64'hB1);
    drv(2, 1, 0, 8'hFF, 64'hB2);
    io_wait = 1;
    #1 chk("bp_ready_wait", req_ready, 0);
    repeat (4) begin
      tick();
      chk("bp_hold_pkt", io_packet, 64'hB1);
      chk("bp_hold_valid", io_valid, 8'hFF);
      #1 chk("bp_hold_ready", req_ready, 0);
    end
    io_wait = 0;
    #1 chk("bp_release", req_ready, 4'b0100);
    tick();
    chk("bp_pkt_b2", io_packet, 64'hB2);
    drv(2, 1, 1, 8'hFF, 64'hB3);
    tick();
    chk("bp_pkt_b3", io_packet, 64'hB3);
    chk("bp_busy_end", busy, 0);
    chk("bp_ptr", dut.ptr, 3);
    drv(2, 0, 0, 8'h00, 64'h0);
    // interleave protection: req 2 stalls mid-packet while req 0 asks
    drv(2, 1, 0, 8'hFF, 64'hC1);
    tick();
    chk("il_grant", grant, 4'b0100);
    tick();
    chk("il_pkt_c1", io_packet, 64'hC1);
    drv(2, 0, 0, 8'hFF, 64'hC2);
    drv(0, 1, 1, 8'h00, 64'hD1);
    repeat (3) begin
      #1 chk("il_no_ready", req_ready, 0);
      tick();
      chk("il_hold_grant", grant, 4'b0100);
    end
    drv(2, 1, 1, 8'hFF, 64'hC2);
    #1 chk("il_ready_c2", req_ready, 4'b0100);
    tick();
    chk("il_pkt_c2", io_packet, 64'hC2);
    chk("il_busy_end", busy, 0);
    drv(2, 0, 0, 8'h00, 64'h0);
    tick();
    chk("il_grant0", grant, 4'b0001);
    #1 chk("il_ready0", req_ready, 4'b0001);
    tick();
    chk("il_drop_valid", io_valid, 0);
    chk("il_drop_pkt", io_packet, 64'hD1);
    chk("il_drop_busy", busy, 0);
    chk("il_ptr", dut.ptr, 1);
    drv(0, 0, 0, 8'h00, 64'h0);
    // enable gating mid-packet
    drv(1, 1, 0, 8'hFF, 64'hE1);
    tick();
    chk("en_grant", grant, 4'b0010);
    en = 0;
    #1 chk("en_ready", req_ready, 4'b0010);
    tick();
    chk("en_pkt_e1", io_packet, 64'hE1);
    drv(1, 1, 1, 8'hFF, 64'hE2);
    tick();
    chk("en_pkt_e2", io_packet, 64'hE2);
    chk("en_busy_end", busy, 0);
    drv(1, 1, 1, 8'hFF, 64'hE3);
    drv(3, 1, 1, 8'hFF, 64'h33);
    repeat (3) begin
      tick();
      chk("en_blocked_busy", busy, 0);
      chk("en_blocked_grant", grant, 0);
    end
    en = 1;
    tick();
    chk("en_regrant", grant, 4'b1000);
    tick();
    chk("en_done", grant, 0);
    chk("en_ptr", dut.ptr, 0);
    drv(1, 0, 0, 8'h00, 64'h0);
    drv(3, 0, 0, 8'h00, 64'h0);
    // reset mid-packet, with ptr moved off zero first
    drv(1, 1, 1, 8'hFF, 64'h51);
    tick();
    chk("rm_grant1", grant, 4'b0010);
    tick();
    chk("rm_ptr2", dut.ptr, 2);
    drv(1, 0, 0, 8'h00, 64'h0);
    drv(2, 1, 0, 8'hFF, 64'hF1);
    tick();
    chk("rm_grant2", grant, 4'b0100);
    tick();
    chk("rm_pkt_f1", io_packet, 64'hF1);
    drv(2, 1, 0, 8'hFF, 64'hF2);
    drv(1, 1, 1, 8'hFF, 64'h61);
    #1 chk("rm_ready_f2", req_ready, 4'b0100);
    nreset = 0;
    #1;
    chk("rm_grant", grant, 0);
    chk("rm_busy", busy, 0);
    chk("rm_io_valid", io_valid, 0);
    chk("rm_io_packet", io_packet, 0);
    chk("rm_ready", req_ready, 0);
    chk("rm_ptr", dut.ptr, 0);
    tick();
    nreset = 1;
    tick();
    chk("rm_restart", grant, 4'b0010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
